// File: rtl/vedic_mac_4bit.sv
// Streaming 4x4 Vedic multiply-accumulate with valid/ready operand and result ports.
// Optional feature: define VEDIC_MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.

module vedic_mul_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] product
);
    logic carry;

    always_comb begin
        carry      = a[1] & b[0] & a[0] & b[1];
        product[0] = a[0] & b[0];
        product[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        product[2] = (a[1] & b[1]) ^ carry;
        product[3] = a[1] & b[1] & carry;
    end
endmodule

module vedic_mul_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;
    logic [5:0] upper;

    vedic_mul_2bit u_ll (.a(a[1:0]), .b(b[1:0]), .product(q0));
    vedic_mul_2bit u_hl (.a(a[3:2]), .b(b[1:0]), .product(q1));
    vedic_mul_2bit u_lh (.a(a[1:0]), .b(b[3:2]), .product(q2));
    vedic_mul_2bit u_hh (.a(a[3:2]), .b(b[3:2]), .product(q3));

    // Vertical-and-crosswise combine: cross terms weigh 4, high term 16.
    always_comb begin
        mid     = {1'b0, q1} + {1'b0, q2};
        upper   = {q3, q0[3:2]} + {1'b0, mid};
        product = {upper, q0[1:0]};
    end
endmodule

module vedic_mac_4bit #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic             p_vld;
    logic [7:0]       product;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [LEN_W-1:0] cnt;
    logic             beat;
    logic             accept_start;

    vedic_mul_4bit u_mul (
        .a       (a_q),
        .b       (b_q),
        .product (product)
    );

    assign in_ready     = (state == RUN);
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign result       = acc;
    assign beat         = in_valid & in_ready;
    assign accept_start = (state == IDLE) & start;
    assign sum          = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, product};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat && cnt == LEN_W'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            p_vld <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept_start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            p_vld <= 1'b0;
            cnt   <= len;
        end else begin
            p_vld <= beat;
            if (beat) begin
                a_q <= a;
                b_q <= b;
                cnt <= cnt - LEN_W'(1);
            end
            if (p_vld) begin
                if (sum[ACC_W]) begin
                    ovf <= 1'b1;
                end
`ifdef VEDIC_MAC_SAT_EN
                acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                acc <= sum[ACC_W-1:0];
`endif
            end
        end
    end
endmodule

// File: tb/tb_vedic_mac_4bit.sv
// Randomized and directed bench for vedic_mac_4bit at ACC_W=16 and ACC_W=10 side by side.
// The reference model sums products with plain arithmetic and applies wrap or saturation per VEDIC_MAC_SAT_EN.

module tb_vedic_mac_4bit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        out_ready;

    logic        in_ready16, out_valid16, ovf16, busy16;
    logic [15:0] result16;
    logic        in_ready10, out_valid10, ovf10, busy10;
    logic [9:0]  result10;

    int checks   = 0;
    int failures = 0;
    int unsigned pa[16];
    int unsigned pb[16];

    vedic_mac_4bit #(.ACC_W(16), .LEN_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
        .out_valid(out_valid16), .out_ready(out_ready),
        .result(result16), .ovf(ovf16), .busy(busy16)
    );

    vedic_mac_4bit #(.ACC_W(10), .LEN_W(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready10), .a(a), .b(b),
        .out_valid(out_valid10), .out_ready(out_ready),
        .result(result10), .ovf(ovf10), .busy(busy10)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned exp_res(input int unsigned total, input int unsigned w);
        int unsigned lim;
        lim = 1 << w;
`ifdef VEDIC_MAC_SAT_EN
        return (total >= lim) ? lim - 1 : total;
`else
        return total % lim;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy16"}, busy16, 0);
        check({tag, "_busy10"}, busy10, 0);
        check({tag, "_oval"}, out_valid16, 0);
        check({tag, "_irdy"}, in_ready16, 0);
    endtask

    task automatic run_mac(input int unsigned n, input int unsigned gap_max,
                           input int unsigned hold, input bit poke);
        int unsigned total;
        int unsigned gap;
        total = 0;
        for (int i = 0; i < int'(n); i++) total += pa[i] * pb[i];

        // Operands offered in IDLE must not be consumed.
        start    = 1'b1;
        len      = 4'(n);
        in_valid = 1'b1;
        a        = 4'($urandom);
        b        = 4'($urandom);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;

        if (n == 0) begin
            check("zero_oval", out_valid16, 1);
            check("zero_irdy", in_ready16, 0);
        end else begin
            check("run_irdy", in_ready16, 1);
            check("run_busy", busy16, 1);
            for (int i = 0; i < int'(n); i++) begin
                gap = $urandom_range(0, gap_max);
                for (int g = 0; g < int'(gap); g++) begin
                    in_valid = 1'b0;
                    start    = poke;
                    tick();
                    check("gap_irdy", in_ready16, 1);
                    check("gap_oval", out_valid16, 0);
                end
                in_valid = 1'b1;
                a        = 4'(pa[i]);
                b        = 4'(pb[i]);
                start    = poke;
                tick();
                start    = 1'b0;
            end
            // Junk operands during DRAIN must be ignored.
            in_valid = 1'b1;
            a        = 4'($urandom);
            b        = 4'($urandom);
            check("drain_oval", out_valid16, 0);
            check("drain_irdy", in_ready16, 0);
            check("drain_busy", busy16, 1);
            tick();
        end

        check("done_oval16", out_valid16, 1);
        check("done_oval10", out_valid10, 1);
        check("done_irdy", in_ready16, 0);
        check("res16", result16, exp_res(total, 16));
        check("ovf16", ovf16, total >= 65536);
        check("res10", result10, exp_res(total, 10));
        check("ovf10", ovf10, total >= 1024);

        for (int h = 0; h < int'(hold); h++) begin
            out_ready = 1'b0;
            start     = poke;
            in_valid  = 1'b1;
            a         = 4'($urandom);
            b         = 4'($urandom);
            tick();
            check("hold_oval", out_valid16, 1);
            check("hold_res16", result16, exp_res(total, 16));
            check("hold_res10", result10, exp_res(total, 10));
        end

        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_idle("ack");
        tick();
        check_idle("post");
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check_idle("rst");
        check("rst_res16", result16, 0);
        check("rst_ovf10", ovf10, 0);
        rst_n = 1'b1;
        tick();

        pa[0] = 11; pb[0] = 14; pa[1] = 10; pb[1] = 12; pa[2] = 13; pb[2] = 9;
        run_mac(3, 0, 0, 1'b0);

        pa[0] = 15; pb[0] = 9; pa[1] = 5; pb[1] = 13; pa[2] = 7; pb[2] = 13; pa[3] = 13; pb[3] = 13;
        run_mac(4, 2, 5, 1'b0);

        run_mac(0, 0, 2, 1'b0);

        for (int i = 0; i < 5; i++) begin
            pa[i] = 15;
            pb[i] = 15;
        end
        run_mac(5, 0, 1, 1'b0);

        pa[0] = 9; pb[0] = 11; pa[1] = 5; pb[1] = 3;
        run_mac(2, 1, 3, 1'b1);

        // Reset after two beats of a four-beat run.
        start = 1'b1;
        len   = 4'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a        = 4'd15;
            b        = 4'd15;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_idle("midrst");
        check("midrst_res16", result16, 0);
        check("midrst_ovf16", ovf16, 0);
        rst_n = 1'b1;
        tick();
        pa[0] = 13; pb[0] = 13;
        run_mac(1, 0, 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int unsigned n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                pa[i] = $urandom_range(0, 15);
                pb[i] = $urandom_range(0, 15);
            end
            run_mac(n, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
